// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard and data-cache miss stall controller.
// Detects load-use hazards (bubble insertion), gates branch flushes, and
// sequences a blocking data-cache miss through IDLE -> MISS_REQ ->
// MISS_WAIT -> REFILL while holding the global stall.
// A sticky timeout flag sets after TIMEOUT cycles spent in MISS_WAIT.
// Optional feature: define STALL_CTRL_PERF_CNT_EN to add saturating
// stall-cycle and load-use bubble counters (stall_cycles_o, loaduse_cnt_o).
//
// Output priority, highest first:
//   stall_o      -> pcwrite/ifid_write held at 1, no bubble, no flush
//   load-use     -> pcwrite/ifid_write = 0, bubble = 1, no flush
//   otherwise    -> ifid_flush_o follows branch_taken_i
// mem_req_o is a single-cycle pulse while in MISS_REQ; mem_ack_i is only
// honoured in MISS_WAIT.
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    input  logic       branch_taken_i,
    input  logic       dcache_req_i,
    input  logic       dcache_hit_i,
    input  logic       mem_ack_i,
    output logic       pcwrite_o,
    output logic       ifid_write_o,
    output logic       idex_bubble_o,
    output logic       ifid_flush_o,
    output logic       stall_o,
    output logic       mem_req_o,
    output logic       timeout_o,
    output logic [1:0] dbg_state_o
`ifdef STALL_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] loaduse_cnt_o
`endif
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        REFILL    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          miss_start;
    logic          load_use;

    assign miss_start  = start_i && dcache_req_i && !dcache_hit_i;
    assign load_use    = idex_memread_i && (idex_rt_i != 5'd0) &&
                         ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    assign dbg_state_o = state_q;

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state, saturating wait counter and timeout detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        mem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_start) state_d = MISS_REQ;
            end
            MISS_REQ: begin
                mem_req_o = 1'b1;
                cnt_d     = '0;
                state_d   = MISS_WAIT;
            end
            MISS_WAIT: begin
                // cnt_d counts this cycle, so the flag rises during the
                // TIMEOUT-th wait cycle rather than one cycle later.
                cnt_d = (cnt_q == TO_MAX) ? cnt_q : cnt_q + CW'(1);
                if (cnt_d == TO_MAX) timeout_d = 1'b1;
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign timeout_o = timeout_q || ((state_q == MISS_WAIT) && (cnt_d == TO_MAX));

    // Pipeline control outputs with stall > load-use > branch priority.
    always_comb begin
        stall_o       = (state_q != IDLE) || miss_start;
        pcwrite_o     = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        if (!stall_o) begin
            if (load_use) begin
                pcwrite_o     = 1'b0;
                ifid_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
            end else begin
                ifid_flush_o = branch_taken_i;
            end
        end
    end

`ifdef STALL_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] loaduse_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cycles_q <= '0;
            loaduse_cnt_q  <= '0;
        end else begin
            if (stall_o && (stall_cycles_q != 32'hFFFF_FFFF))
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (idex_bubble_o && (loaduse_cnt_q != 32'hFFFF_FFFF))
                loaduse_cnt_q <= loaduse_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign loaduse_cnt_o  = loaduse_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks for hazard_stall_ctrl.
// u_dut uses the default TIMEOUT, u_dut_to uses TIMEOUT=3; both share the
// same inputs. Inputs change 2 time units after a rising edge and outputs
// are sampled 1 unit later, well away from either clock edge.
// Output vector order: {pcwrite, ifid_write, bubble, flush, stall, mem_req}.
module tb_hazard_stall_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b1;
    logic       idex_memread_i = 1'b0;
    logic [4:0] idex_rt_i = 5'd0;
    logic [4:0] ifid_rs_i = 5'd0;
    logic [4:0] ifid_rt_i = 5'd0;
    logic       branch_taken_i = 1'b0;
    logic       dcache_req_i = 1'b0;
    logic       dcache_hit_i = 1'b0;
    logic       mem_ack_i = 1'b0;

    logic pcwrite_o, ifid_write_o, idex_bubble_o, ifid_flush_o;
    logic stall_o, mem_req_o, timeout_o;
    logic [1:0] dbg_state_o;
    logic to_pcwrite, to_ifid_write, to_bubble, to_flush;
    logic to_stall, to_mem_req, to_timeout;
    logic [1:0] to_state;
`ifdef STALL_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles_o, loaduse_cnt_o, to_stall_cycles, to_loaduse_cnt;
`endif

    logic [5:0] outs;
    assign outs = {pcwrite_o, ifid_write_o, idex_bubble_o, ifid_flush_o, stall_o, mem_req_o};

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .branch_taken_i(branch_taken_i), .dcache_req_i(dcache_req_i),
        .dcache_hit_i(dcache_hit_i), .mem_ack_i(mem_ack_i),
        .pcwrite_o(pcwrite_o), .ifid_write_o(ifid_write_o),
        .idex_bubble_o(idex_bubble_o), .ifid_flush_o(ifid_flush_o),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .timeout_o(timeout_o),
        .dbg_state_o(dbg_state_o)
`ifdef STALL_CTRL_PERF_CNT_EN
        , .stall_cycles_o(stall_cycles_o), .loaduse_cnt_o(loaduse_cnt_o)
`endif
    );

    hazard_stall_ctrl #(.TIMEOUT(3)) u_dut_to (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .branch_taken_i(branch_taken_i), .dcache_req_i(dcache_req_i),
        .dcache_hit_i(dcache_hit_i), .mem_ack_i(mem_ack_i),
        .pcwrite_o(to_pcwrite), .ifid_write_o(to_ifid_write),
        .idex_bubble_o(to_bubble), .ifid_flush_o(to_flush),
        .stall_o(to_stall), .mem_req_o(to_mem_req), .timeout_o(to_timeout),
        .dbg_state_o(to_state)
`ifdef STALL_CTRL_PERF_CNT_EN
        , .stall_cycles_o(to_stall_cycles), .loaduse_cnt_o(to_loaduse_cnt)
`endif
    );

    // Clock generation.
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_inputs();
        start_i        = 1'b1;
        idex_memread_i = 1'b0;
        idex_rt_i      = 5'd0;
        ifid_rs_i      = 5'd0;
        ifid_rt_i      = 5'd0;
        branch_taken_i = 1'b0;
        dcache_req_i   = 1'b0;
        dcache_hit_i   = 1'b0;
        mem_ack_i      = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (outs !== 6'b110000) begin
            errors++;
            $display("FAIL reset_outs: got %b want %b", outs, 6'b110000);
        end
        checks++;
        if ({timeout_o, to_timeout} !== 2'b00) begin
            errors++;
            $display("FAIL reset_timeout: got %b want 00", {timeout_o, to_timeout});
        end
        checks++;
        if (dbg_state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", dbg_state_o);
        end
`ifdef STALL_CTRL_PERF_CNT_EN
        checks++;
        if ({stall_cycles_o, loaduse_cnt_o} !== 64'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cycles_o, loaduse_cnt_o);
        end
`endif
    endtask

    typedef struct {
        logic       memread;
        logic [4:0] rt;
        logic [4:0] rs;
        logic [4:0] ift;
        logic       br;
        logic [5:0] exp;
    } lu_vec_t;

    task automatic test_load_use();
        lu_vec_t tbl [7];
        tbl = '{
            '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 6'b001000},  // rt matches rs
            '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'b110000},  // r0 never hazards
            '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 6'b001000},  // rt matches ifid rt
            '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 6'b110000},  // not a load
            '{1'b1, 5'd5, 5'd6, 5'd4, 1'b0, 6'b110000},  // no register match
            '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 6'b001000},  // load-use beats branch
            '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 6'b110100}   // plain taken branch
        };
        for (int i = 0; i < 7; i++) begin
            step();
            idex_memread_i = tbl[i].memread;
            idex_rt_i      = tbl[i].rt;
            ifid_rs_i      = tbl[i].rs;
            ifid_rt_i      = tbl[i].ift;
            branch_taken_i = tbl[i].br;
            #1;
            checks++;
            if (outs !== tbl[i].exp) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b want %b", i, outs, tbl[i].exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_branch_priority();
        step();
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd9;
        ifid_rt_i      = 5'd9;
        branch_taken_i = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b001000) begin
            errors++;
            $display("FAIL branch_vs_loaduse: got %b want %b", outs, 6'b001000);
        end
        step();
        idex_memread_i = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b110100) begin
            errors++;
            $display("FAIL branch_reresolve: got %b want %b", outs, 6'b110100);
        end
        idle_inputs();
    endtask

    task automatic test_no_miss();
        step();
        dcache_req_i = 1'b1;
        dcache_hit_i = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b110000) begin
            errors++;
            $display("FAIL hit_no_stall: got %b want %b", outs, 6'b110000);
        end
        dcache_hit_i = 1'b0;
        start_i      = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b110000) begin
            errors++;
            $display("FAIL start_low_no_stall: got %b want %b", outs, 6'b110000);
        end
        step();
        #1;
        checks++;
        if (dbg_state_o !== 2'd0) begin
            errors++;
            $display("FAIL start_low_state: got %0d want 0", dbg_state_o);
        end
        idle_inputs();
    endtask

    // Miss at cycle 0 with a load-use and branch also present, spurious ack
    // in MISS_REQ, start_i dropped mid-miss, real ack at cycle 4.
    task automatic test_miss();
        logic [5:0] exp_o  [7];
        logic [1:0] exp_st [7];
        exp_o  = '{6'b110010, 6'b110011, 6'b110010, 6'b110010, 6'b110010, 6'b110010, 6'b110000};
        exp_st = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) step();
            dcache_req_i   = (c == 0);
            dcache_hit_i   = 1'b0;
            start_i        = !(c >= 2 && c <= 5);
            mem_ack_i      = (c == 1) || (c == 4);
            idex_memread_i = (c == 0);
            idex_rt_i      = 5'd5;
            ifid_rs_i      = 5'd5;
            branch_taken_i = (c == 0);
            #1;
            checks++;
            if (outs !== exp_o[c]) begin
                errors++;
                $display("FAIL miss_outs[c%0d]: got %b want %b", c, outs, exp_o[c]);
            end
            checks++;
            if (dbg_state_o !== exp_st[c]) begin
                errors++;
                $display("FAIL miss_state[c%0d]: got %0d want %0d", c, dbg_state_o, exp_st[c]);
            end
        end
        idle_inputs();
    endtask

    // TIMEOUT=3 instance: flag on the 3rd MISS_WAIT cycle (cycle 4), ack at
    // cycle 6, back in IDLE at cycle 8 with the flag still set.
    task automatic test_timeout();
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) step();
            dcache_req_i = (c == 0);
            mem_ack_i    = (c == 6);
            #1;
            checks++;
            if (to_timeout !== (c >= 4)) begin
                errors++;
                $display("FAIL timeout[c%0d]: got %b want %b", c, to_timeout, (c >= 4));
            end
            checks++;
            if (to_stall !== (c <= 7)) begin
                errors++;
                $display("FAIL timeout_stall[c%0d]: got %b want %b", c, to_stall, (c <= 7));
            end
        end
        step();
        step();
        #1;
        checks++;
        if ({to_timeout, timeout_o} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_sticky: got %b want 10", {to_timeout, timeout_o});
        end
        idle_inputs();
    endtask

    // Asynchronous reset in the middle of MISS_WAIT; runs right after
    // test_timeout so the TIMEOUT=3 flag is already set.
    task automatic test_reset_mid_miss();
        step();
        dcache_req_i = 1'b1;
        step();
        dcache_req_i = 1'b0;
        step();
        step();
        #1;
        checks++;
        if ({to_timeout, stall_o, dbg_state_o} !== 4'b1110) begin
            errors++;
            $display("FAIL pre_reset: got %b want 1110", {to_timeout, stall_o, dbg_state_o});
        end
        #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({stall_o, to_stall, to_timeout, mem_req_o} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got %b want 0000", {stall_o, to_stall, to_timeout, mem_req_o});
        end
        step();
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            checks++;
            if ({outs, to_mem_req} !== 7'b1100000) begin
                errors++;
                $display("FAIL post_reset[%0d]: got %b want 1100000", c, {outs, to_mem_req});
            end
        end
    endtask

    // Miss acked in its first MISS_WAIT cycle, second miss issued the cycle
    // the FSM returns to IDLE.
    task automatic test_back_to_back();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) step();
            dcache_req_i = (c == 0) || (c == 4);
            mem_ack_i    = (c == 2) || (c == 6);
            #1;
            checks++;
            if ({stall_o, mem_req_o} !== {(c <= 7), (c == 1 || c == 5)}) begin
                errors++;
                $display("FAIL b2b[c%0d]: got %b want %b", c, {stall_o, mem_req_o},
                         {(c <= 7), (c == 1 || c == 5)});
            end
        end
        idle_inputs();
    endtask

`ifdef STALL_CTRL_PERF_CNT_EN
    // Shortest miss stalls 4 cycles: IDLE(miss), MISS_REQ, MISS_WAIT(ack),
    // REFILL. Then two load-use bubbles.
    task automatic test_perf();
        apply_reset();
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) step();
            dcache_req_i = (c == 0);
            mem_ack_i    = (c == 2);
        end
        #1;
        checks++;
        if (stall_cycles_o !== 32'd4) begin
            errors++;
            $display("FAIL perf_stall: got %0d want 4", stall_cycles_o);
        end
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd3;
        ifid_rs_i      = 5'd3;
        step();
        step();
        idle_inputs();
        #1;
        checks++;
        if (loaduse_cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL perf_loaduse: got %0d want 2", loaduse_cnt_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_no_miss();
        test_miss();
        test_timeout();
        test_reset_mid_miss();
        test_back_to_back();
`ifdef STALL_CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
